// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: data-hazard freeze/bubble,
// mult/div busy sequencer and a saturating stall-cycle counter.
//
// state | meaning
// IDLE  | mult/div unit free, a start loads the busy count
// BUSY  | mult/div running, md_cnt counts remaining busy cycles down to 1
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [1:0]             id_rs_tuse,
  input  logic [1:0]             id_rt_tuse,
  input  logic [4:0]             ex_dst,
  input  logic [1:0]             ex_tnew,
  input  logic [4:0]             mem_dst,
  input  logic [1:0]             mem_tnew,
  input  logic                   id_md_use,
  input  logic                   ex_md_start,
  input  logic                   ex_md_kind,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_flush,
  output logic                   md_busy,
  output logic [CNT_W-1:0]       md_cnt,
  output logic                   md_done,
  output logic                   md_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  md_state_t              state_q, state_d;
  logic [CNT_W-1:0]       md_cnt_q, md_cnt_d;
  logic                   md_done_q, md_done_d;
  logic                   md_err_q, md_err_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic data_stall;
  logic md_stall;
  logic stall;

  // A source register is hazardous when a producer in E or M will not have
  // its result forwardable by the time this instruction needs it.
  function automatic logic hz(input logic [4:0] a, input logic [1:0] tuse,
                              input logic [4:0] e_dst, input logic [1:0] e_tnew,
                              input logic [4:0] m_dst, input logic [1:0] m_tnew);
    return (a != 5'd0) &&
           (((a == e_dst) && (tuse < e_tnew)) ||
            ((a == m_dst) && (tuse < m_tnew)));
  endfunction

  always_comb begin
    data_stall = hz(id_rs, id_rs_tuse, ex_dst, ex_tnew, mem_dst, mem_tnew) |
                 hz(id_rt, id_rt_tuse, ex_dst, ex_tnew, mem_dst, mem_tnew);
    md_stall   = id_md_use && ((state_q == BUSY) || ex_md_start);
    stall      = ~reset & (data_stall | md_stall);
  end

  always_comb begin
    state_d        = state_q;
    md_cnt_d       = md_cnt_q;
    md_done_d      = 1'b0;
    md_err_d       = md_err_q;
    stall_cycles_d = stall_cycles_q;

    case (state_q)
      IDLE: begin
        if (ex_md_start) begin
          state_d  = BUSY;
          md_cnt_d = ex_md_kind ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        // A start while busy is dropped; only the sticky error records it.
        if (ex_md_start) md_err_d = 1'b1;
        if (md_cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          md_cnt_d  = '0;
          md_done_d = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = '0;
      end
    endcase

    if (stall && (stall_cycles_q != {STALL_CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      md_cnt_q       <= '0;
      md_done_q      <= 1'b0;
      md_err_q       <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      md_cnt_q       <= md_cnt_d;
      md_done_q      <= md_done_d;
      md_err_q       <= md_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pc_en        = ~stall;
  assign ifid_en      = ~stall;
  assign idex_flush   = stall;
  assign md_busy      = (state_q == BUSY);
  assign md_cnt       = md_cnt_q;
  assign md_done      = md_done_q;
  assign md_err       = md_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic against a
// remaining-cycles model of the mult/div unit and the hazard rule.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic [1:0] id_rs_tuse, id_rt_tuse, ex_tnew, mem_tnew;
  logic       id_md_use, ex_md_start, ex_md_kind;

  logic        pc_en, ifid_en, idex_flush, md_busy, md_done, md_err;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cycles;
  logic        w4_pc_en, w4_ifid_en, w4_idex_flush, w4_md_busy, w4_md_done, w4_md_err;
  logic [3:0]  w4_md_cnt;
  logic [3:0]  w4_stall_cycles;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  int      m_rem;
  bit      m_done, m_err;
  longint  m_cnt32, m_cnt4;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse),
    .ex_dst(ex_dst), .ex_tnew(ex_tnew), .mem_dst(mem_dst), .mem_tnew(mem_tnew),
    .id_md_use(id_md_use), .ex_md_start(ex_md_start), .ex_md_kind(ex_md_kind),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_flush(idex_flush),
    .md_busy(md_busy), .md_cnt(md_cnt), .md_done(md_done), .md_err(md_err),
    .stall_cycles(stall_cycles)
  );

  pipe_stall_ctrl #(.STALL_CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse),
    .ex_dst(ex_dst), .ex_tnew(ex_tnew), .mem_dst(mem_dst), .mem_tnew(mem_tnew),
    .id_md_use(id_md_use), .ex_md_start(ex_md_start), .ex_md_kind(ex_md_kind),
    .pc_en(w4_pc_en), .ifid_en(w4_ifid_en), .idex_flush(w4_idex_flush),
    .md_busy(w4_md_busy), .md_cnt(w4_md_cnt), .md_done(w4_md_done), .md_err(w4_md_err),
    .stall_cycles(w4_stall_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_hz(input int a, input int tuse);
    if (a == 0) return 1'b0;
    if (a == int'(ex_dst) && tuse < int'(ex_tnew)) return 1'b1;
    if (a == int'(mem_dst) && tuse < int'(mem_tnew)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit ds, ms;
    ds = m_hz(int'(id_rs), int'(id_rs_tuse)) || m_hz(int'(id_rt), int'(id_rt_tuse));
    ms = id_md_use && (m_rem > 0 || ex_md_start);
    return !reset && (ds || ms);
  endfunction

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_rs_tuse = 3; id_rt_tuse = 3;
    ex_dst = 0; ex_tnew = 0; mem_dst = 0; mem_tnew = 0;
    id_md_use = 0; ex_md_start = 0; ex_md_kind = 0;
  endtask

  // Compare everything against the model, then advance one clock.
  task automatic step();
    bit s;
    #1;
    s = m_stall();
    chk("pc_en", pc_en, !s);
    chk("ifid_en", ifid_en, !s);
    chk("idex_flush", idex_flush, s);
    chk("md_busy", md_busy, m_rem > 0);
    chk("md_cnt", md_cnt, m_rem);
    chk("md_done", md_done, m_done);
    chk("md_err", md_err, m_err);
    chk("stall_cycles", stall_cycles, m_cnt32);
    chk("w4_stall_cycles", w4_stall_cycles, m_cnt4);
    @(posedge clk);
    if (reset) begin
      m_rem = 0; m_done = 0; m_err = 0; m_cnt32 = 0; m_cnt4 = 0;
    end else begin
      if (s) begin
        if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_done = 0;
      if (m_rem > 0) begin
        if (ex_md_start) m_err = 1;
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end else if (ex_md_start) begin
        m_rem = ex_md_kind ? 10 : 5;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  initial begin
    m_rem = 0; m_done = 0; m_err = 0; m_cnt32 = 0; m_cnt4 = 0;
    reset = 1;
    idle_inputs();
    @(negedge clk);

    // 1. reset then idle
    do_reset();
    #1;
    chk("t1_pc_en", pc_en, 1);
    chk("t1_ifid_en", ifid_en, 1);
    chk("t1_flush", idex_flush, 0);
    chk("t1_busy", md_busy, 0);
    chk("t1_cnt", stall_cycles, 0);
    step();

    // 2. load-use hazards
    ex_dst = 5; ex_tnew = 2; id_rs = 5; id_rs_tuse = 1;
    #1;
    chk("t2_pc_en", pc_en, 0);
    chk("t2_flush", idex_flush, 1);
    step();
    id_rs = 0;
    #1;
    chk("t2_r0_pc_en", pc_en, 1);
    step();
    ex_dst = 0; ex_tnew = 0; mem_dst = 5; mem_tnew = 1; id_rs = 5; id_rs_tuse = 0;
    #1;
    chk("t2_mem_flush", idex_flush, 1);
    step();

    // 3. mult with id_md_use held
    do_reset();
    id_md_use = 1; ex_md_start = 1; ex_md_kind = 0;
    step();
    ex_md_start = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_busy", md_busy, 1);
      chk("t3_cnt", md_cnt, 5 - i);
      chk("t3_stall", pc_en, 0);
      step();
    end
    #1;
    chk("t3_done", md_done, 1);
    chk("t3_busy_end", md_busy, 0);
    chk("t3_stall_cycles", stall_cycles, 6);
    id_md_use = 0;
    step();
    #1;
    chk("t3_done_once", md_done, 0);

    // 4. div interrupted by reset
    do_reset();
    id_md_use = 1; ex_md_start = 1; ex_md_kind = 1;
    step();
    ex_md_start = 0;
    for (int i = 0; i < 4; i++) step();
    reset = 1;
    step();
    reset = 0; id_md_use = 0;
    #1;
    chk("t4_busy", md_busy, 0);
    chk("t4_cnt", md_cnt, 0);
    chk("t4_done", md_done, 0);
    chk("t4_stall_cycles", stall_cycles, 0);
    step();
    #1;
    chk("t4_no_done", md_done, 0);

    // 5. start while busy
    do_reset();
    ex_md_start = 1; ex_md_kind = 0;
    step();
    ex_md_start = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_cnt", md_cnt, 5 - i);
      ex_md_start = (i == 1);
      ex_md_kind  = 1;
      step();
      ex_md_start = 0;
    end
    #1;
    chk("t5_err", md_err, 1);
    chk("t5_done", md_done, 1);
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("t5_err_sticky", md_err, 1);

    // 6. saturation of narrow counter
    do_reset();
    ex_dst = 7; ex_tnew = 3; id_rt = 7; id_rt_tuse = 0;
    for (int i = 0; i < 20; i++) step();
    #1;
    chk("t6_sat", w4_stall_cycles, 15);
    chk("t6_wide", stall_cycles, 20);
    idle_inputs();

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) < 2);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_rs_tuse  = 2'($urandom_range(0, 3));
      id_rt_tuse  = 2'($urandom_range(0, 3));
      ex_dst      = 5'($urandom_range(0, 3));
      ex_tnew     = 2'($urandom_range(0, 3));
      mem_dst     = 5'($urandom_range(0, 3));
      mem_tnew    = 2'($urandom_range(0, 3));
      id_md_use   = ($urandom_range(0, 9) < 3);
      ex_md_start = ($urandom_range(0, 99) < 15);
      ex_md_kind  = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
